// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide synchronous memory with lane steering and load extension.
// Build option LSU_MISALIGNED_EN: split misaligned accesses into two word cycles; when undefined they are rejected.
//
// state | meaning
// IDLE  | ready for a new request
// ACC0  | first (or only) memory cycle
// ACC1  | second memory cycle of a split access
// WAIT  | last read data arrives from memory
// RESP  | one-cycle completion pulse

module load_store_unit (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_op_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wr_data_i,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_wr_enable_o,
   output logic        mem_rd_enable_o,
   output logic [31:0] mem_wr_data_o,
   input  logic [31:0] mem_rd_data_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic        resp_error_o
);

   typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic        split_q, split_d;
   logic [31:0] word0_q, word0_d;

   logic        ready_q, ready_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_we_q, mem_we_d;
   logic        mem_re_q, mem_re_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_error_q, resp_error_d;

   logic        req_illegal, req_misaligned;
   logic [7:0]  size_mask, lane_mask;
   logic [63:0] load_dword;
   logic [31:0] load_shift, load_result;

   always_comb begin
      req_illegal    = (req_op_i == 3'b011) || (req_op_i[2:1] == 2'b11) || (req_we_i && req_op_i[2]);
      req_misaligned = ((req_op_i[1:0] == 2'b01) && (req_addr_i[1:0] == 2'b11)) ||
                       ((req_op_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));

      // For a split access the first word was captured during ACC1; the second is on the bus now.
      load_dword = split_q ? {mem_rd_data_i, word0_q} : {32'h0, mem_rd_data_i};
      load_shift = 32'(load_dword >> {addr_q[1:0], 3'b000});
      case (op_q[1:0])
         2'b00:   load_result = {{24{load_shift[7]  & ~op_q[2]}}, load_shift[7:0]};
         2'b01:   load_result = {{16{load_shift[15] & ~op_q[2]}}, load_shift[15:0]};
         default: load_result = load_shift;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      split_d     = split_q;
      word0_d     = word0_q;
      resp_data_d = 32'h0;

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               state_d = ACC0;
               we_d    = req_we_i;
               op_d    = req_op_i;
               addr_d  = req_addr_i;
               wdata_d = req_wr_data_i;
`ifdef LSU_MISALIGNED_EN
               err_d   = req_illegal;
               split_d = req_misaligned && !req_illegal;
`else
               err_d   = req_illegal || req_misaligned;
               split_d = 1'b0;
`endif
            end
         end
         ACC0: state_d = split_q ? ACC1 : WAIT;
         ACC1: begin
            word0_d = mem_rd_data_i;
            state_d = WAIT;
         end
         WAIT: begin
            state_d = RESP;
            if (!err_q && !we_q) resp_data_d = load_result;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they appear registered in the cycle they describe.
      size_mask   = (op_d[1:0] == 2'b00) ? 8'h01 : (op_d[1:0] == 2'b01) ? 8'h03 : 8'h0F;
      lane_mask   = size_mask << addr_d[1:0];
      mem_addr_d  = 32'h0;
      mem_we_d    = 4'h0;
      mem_re_d    = 1'b0;
      mem_wdata_d = 32'h0;
      if (!err_d && (state_d == ACC0 || state_d == ACC1)) begin
         mem_addr_d = {addr_d[31:2], 2'b00} + ((state_d == ACC1) ? 32'd4 : 32'd0);
         if (we_d) begin
            if (state_d == ACC1) begin
               mem_we_d    = lane_mask[7:4];
               mem_wdata_d = wdata_d >> (6'd32 - {1'b0, addr_d[1:0], 3'b000});
            end else begin
               mem_we_d    = lane_mask[3:0];
               mem_wdata_d = wdata_d << {addr_d[1:0], 3'b000};
            end
         end else begin
            mem_re_d = 1'b1;
         end
      end
      resp_valid_d = (state_d == RESP);
      resp_error_d = (state_d == RESP) && err_d;
      ready_d      = (state_d == IDLE);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         op_q         <= 3'b000;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         err_q        <= 1'b0;
         split_q      <= 1'b0;
         word0_q      <= 32'h0;
         ready_q      <= 1'b1;
         mem_addr_q   <= 32'h0;
         mem_we_q     <= 4'h0;
         mem_re_q     <= 1'b0;
         mem_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'h0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         split_q      <= split_d;
         word0_q      <= word0_d;
         ready_q      <= ready_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
      end
   end

   assign req_ready_o     = ready_q;
   assign mem_addr_o      = mem_addr_q;
   assign mem_wr_enable_o = mem_we_q;
   assign mem_rd_enable_o = mem_re_q;
   assign mem_wr_data_o   = mem_wdata_q;
   assign resp_valid_o    = resp_valid_q;
   assign resp_data_o     = resp_data_q;
   assign resp_error_o    = resp_error_q;

endmodule
